pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard and stall controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB latches). It generates per-latch enable/flush, PC enable and PC source select. Sequential features:
- multi-cycle load-use stall FSM,
- optional no-forwarding RAW interlock,
- sticky halt,
- saturating stall and flush performance counters.
It replaces the purely combinational hazard logic between the datapath latches and the PC.

---
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: latch enables/flushes,
// PC control, load-use stall FSM, sticky halt and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16,
  parameter int LU_STALL = 1,
  parameter int FWD_EN   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_EX_MEM,
  input  logic             dREN_ID_EX,
  input  logic [REG_W-1:0] Rs_IF_ID,
  input  logic [REG_W-1:0] Rt_IF_ID,
  input  logic             uses_rt_IF_ID,
  input  logic [REG_W-1:0] Rd_ID_EX,
  input  logic             wen_ID_EX,
  input  logic [REG_W-1:0] Rd_EX_MEM,
  input  logic             wen_EX_MEM,
  input  logic             br_taken_EX_MEM,
  input  logic             jump_EX_MEM,
  input  logic             jr_EX_MEM,
  input  logic             halt_MEM_WB,
  output logic             enable_IF_ID,
  output logic             enable_ID_EX,
  output logic             enable_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             flush_MEM_WB,
  output logic             enable_pc,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int LW = $clog2(LU_STALL + 1);

  typedef enum logic [1:0] {RUN, LU, HALT} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lu_q, lu_d;
  logic [CNT_W-1:0] scnt_q, fcnt_q;
  logic             stall_inc, flush_inc;
  logic             redirect, freeze, lu_det, raw;
  logic [1:0]       sel;

  function automatic logic dep(input logic [REG_W-1:0] rs,
                               input logic [REG_W-1:0] rt,
                               input logic             use_rt,
                               input logic [REG_W-1:0] r);
    return (r != '0) && ((rs == r) || (use_rt && (rt == r)));
  endfunction

  assign redirect = br_taken_EX_MEM | jump_EX_MEM | jr_EX_MEM;
  assign freeze   = dmem_req_EX_MEM & ~dhit;
  assign lu_det   = (state_q == RUN) & dREN_ID_EX &
                    dep(Rs_IF_ID, Rt_IF_ID, uses_rt_IF_ID, Rd_ID_EX);
  assign raw      = (FWD_EN == 0) &&
                    ((wen_ID_EX &&
                      dep(Rs_IF_ID, Rt_IF_ID, uses_rt_IF_ID, Rd_ID_EX)) ||
                     (wen_EX_MEM &&
                      dep(Rs_IF_ID, Rt_IF_ID, uses_rt_IF_ID, Rd_EX_MEM)));

  always_comb begin
    sel = 2'b00;
    if (jr_EX_MEM)            sel = 2'b11;
    else if (jump_EX_MEM)     sel = 2'b10;
    else if (br_taken_EX_MEM) sel = 2'b01;
  end

  always_comb begin
    enable_IF_ID  = 1'b0;
    enable_ID_EX  = 1'b0;
    enable_EX_MEM = 1'b0;
    enable_MEM_WB = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    flush_EX_MEM  = 1'b0;
    flush_MEM_WB  = 1'b0;
    enable_pc     = 1'b0;
    pc_sel        = 2'b00;
    halted        = 1'b0;
    state_d       = state_q;
    lu_d          = lu_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (RST) begin
      flush_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
      flush_MEM_WB = 1'b1;
    end else if (state_q == HALT) begin
      flush_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
      halted       = 1'b1;
    end else if (halt_MEM_WB) begin
      enable_MEM_WB = 1'b1;
      state_d       = HALT;
    end else if (freeze) begin
      stall_inc = 1'b1;
    end else if (redirect) begin
      enable_IF_ID  = 1'b1;
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      flush_IF_ID   = 1'b1;
      flush_ID_EX   = 1'b1;
      flush_EX_MEM  = 1'b1;
      enable_pc     = 1'b1;
      pc_sel        = sel;
      state_d       = RUN;
      lu_d          = '0;
      flush_inc     = 1'b1;
    end else if ((state_q == LU) || lu_det || raw) begin
      // bubble into ID/EX while IF/ID and PC hold the dependent instruction
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      flush_ID_EX   = 1'b1;
      stall_inc     = 1'b1;
      if (state_q == LU) begin
        lu_d = (lu_q > LW'(1)) ? lu_q - LW'(1) : '0;
        if (lu_q <= LW'(1)) state_d = RUN;
      end else if (lu_det && (LU_STALL > 1)) begin
        state_d = LU;
        lu_d    = LW'(LU_STALL - 1);
      end
    end else if (!ihit) begin
      enable_IF_ID  = 1'b1;
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      flush_IF_ID   = 1'b1;
      stall_inc     = 1'b1;
    end else begin
      enable_IF_ID  = 1'b1;
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      enable_pc     = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      lu_q    <= '0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
      if (stall_inc && (scnt_q != '1)) scnt_q <= scnt_q + CNT_W'(1);
      if (flush_inc && (fcnt_q != '1)) fcnt_q <= fcnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = scnt_q;
  assign flush_cnt = fcnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: four parameter variants share one
// stimulus stream; each scenario checks the variant it targets.
module tb_pipeline_hazard_ctrl;

  // {en IF,IDEX,EXMEM,MEMWB, fl IF,IDEX,EXMEM,MEMWB, enable_pc, pc_sel, halted}
  localparam logic [11:0] P_RST  = 12'h0F0;
  localparam logic [11:0] P_RUN  = 12'hF08;
  localparam logic [11:0] P_STL  = 12'h740;
  localparam logic [11:0] P_NOI  = 12'hF80;
  localparam logic [11:0] P_FRZ  = 12'h000;
  localparam logic [11:0] P_BR   = 12'hFEA;
  localparam logic [11:0] P_JMP  = 12'hFEC;
  localparam logic [11:0] P_JR   = 12'hFEE;
  localparam logic [11:0] P_HLT  = 12'h0E1;
  localparam logic [11:0] P_HWB  = 12'h100;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       ihit, dhit, dmem_req, dren, uses_rt;
  logic       wen_ex, wen_mem, br, jmp, jr, hlt;
  logic [4:0] rs, rt, rd_ex, rd_mem;

  wire [11:0] o    [4];
  wire [15:0] scnt [4];
  wire [15:0] fcnt [4];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  for (genvar k = 0; k < 4; k++) begin : g
    localparam int LS = (k == 1) ? 3 : 1;
    localparam int FW = (k == 2) ? 0 : 1;
    localparam int CW = (k == 3) ? 4 : 16;
    logic [CW-1:0] sc, fc;
    pipeline_hazard_ctrl #(
      .REG_W(5), .CNT_W(CW), .LU_STALL(LS), .FWD_EN(FW)
    ) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .dmem_req_EX_MEM(dmem_req), .dREN_ID_EX(dren),
      .Rs_IF_ID(rs), .Rt_IF_ID(rt), .uses_rt_IF_ID(uses_rt),
      .Rd_ID_EX(rd_ex), .wen_ID_EX(wen_ex),
      .Rd_EX_MEM(rd_mem), .wen_EX_MEM(wen_mem),
      .br_taken_EX_MEM(br), .jump_EX_MEM(jmp), .jr_EX_MEM(jr),
      .halt_MEM_WB(hlt),
      .enable_IF_ID(o[k][11]), .enable_ID_EX(o[k][10]),
      .enable_EX_MEM(o[k][9]), .enable_MEM_WB(o[k][8]),
      .flush_IF_ID(o[k][7]), .flush_ID_EX(o[k][6]),
      .flush_EX_MEM(o[k][5]), .flush_MEM_WB(o[k][4]),
      .enable_pc(o[k][3]), .pc_sel(o[k][2:1]), .halted(o[k][0]),
      .stall_cnt(sc), .flush_cnt(fc)
    );
    assign scnt[k] = 16'(sc);
    assign fcnt[k] = 16'(fc);
  end

  task automatic chk(input string tag, input int k, input logic [11:0] exp);
    checks++;
    assert (o[k] === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o[k], exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; dmem_req = 1'b0; dren = 1'b0;
    uses_rt = 1'b0; wen_ex = 1'b0; wen_mem = 1'b0;
    br = 1'b0; jmp = 1'b0; jr = 1'b0; hlt = 1'b0;
    rs = '0; rt = '0; rd_ex = '0; rd_mem = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    idle();
    #1 RST = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) chk("reset_outputs", k, P_RST);
    chkc("reset_stall_cnt", scnt[0], 16'd0);
    chkc("reset_flush_cnt", fcnt[3], 16'd0);
    tick();
    RST = 1'b0;
    #1 chk("idle_run", 0, P_RUN);

    // load-use, LU_STALL=1
    tick();
    dren = 1'b1; rd_ex = 5'd3; rs = 5'd3;
    #1 chk("lu1_stall", 0, P_STL);
    tick(); idle();
    #1 chk("lu1_resume", 0, P_RUN);
    chkc("lu1_stall_cnt", scnt[0], 16'd1);
    dren = 1'b1; rd_ex = 5'd0; rs = 5'd0;
    #1 chk("lu_r0_nomatch", 0, P_RUN);
    tick(); idle();
    dren = 1'b1; rd_ex = 5'd4; rt = 5'd4; uses_rt = 1'b1;
    #1 chk("lu_rt_stall", 0, P_STL);
    tick(); idle();
    #1 chkc("lu_rt_stall_cnt", scnt[0], 16'd2);

    // LU_STALL=3 with a 2-cycle memory freeze in the middle
    do_reset();
    dren = 1'b1; rd_ex = 5'd3; rs = 5'd3;
    #1 chk("lu3_c1", 1, P_STL);
    tick(); idle();
    #1 chk("lu3_c2", 1, P_STL);
    tick(); dmem_req = 1'b1; dhit = 1'b0;
    #1 chk("lu3_freeze1", 1, P_FRZ);
    tick();
    #1 chk("lu3_freeze2", 1, P_FRZ);
    tick(); idle();
    #1 chk("lu3_c3", 1, P_STL);
    tick();
    #1 chk("lu3_resume", 1, P_RUN);
    chkc("lu3_stall_cnt", scnt[1], 16'd5);

    // branch aborts the LU sequence
    do_reset();
    dren = 1'b1; rd_ex = 5'd3; rs = 5'd3;
    #1 chk("lubr_c1", 1, P_STL);
    tick(); idle(); br = 1'b1;
    #1 chk("lubr_redirect", 1, P_BR);
    tick(); idle();
    #1 chk("lubr_run", 1, P_RUN);
    chkc("lubr_flush_cnt", fcnt[1], 16'd1);
    chkc("lubr_stall_cnt", scnt[1], 16'd1);

    // no-forwarding RAW interlock
    do_reset();
    wen_ex = 1'b1; rd_ex = 5'd5; rt = 5'd5; uses_rt = 1'b1;
    #1 chk("raw_ex", 2, P_STL);
    chk("raw_fwd_nostall", 0, P_RUN);
    tick(); wen_ex = 1'b0; rd_ex = '0; wen_mem = 1'b1; rd_mem = 5'd5;
    #1 chk("raw_mem", 2, P_STL);
    tick(); idle(); rt = 5'd5; uses_rt = 1'b1;
    #1 chk("raw_done", 2, P_RUN);
    chkc("raw_stall_cnt", scnt[2], 16'd2);
    tick(); idle(); wen_ex = 1'b1; rd_ex = 5'd0;
    #1 chk("raw_r0", 2, P_RUN);
    tick(); idle(); wen_ex = 1'b1; rd_ex = 5'd7; rt = 5'd7; rs = 5'd1;
    #1 chk("raw_no_use_rt", 2, P_RUN);
    tick(); idle(); jr = 1'b1; jmp = 1'b1;
    #1 chk("sel_jr_over_jump", 2, P_JR);
    tick(); idle(); jmp = 1'b1; br = 1'b1;
    #1 chk("sel_jump_over_br", 2, P_JMP);
    tick(); idle();
    #1 chkc("raw_flush_cnt", fcnt[2], 16'd2);

    // ihit miss, then halt and asynchronous reset
    do_reset();
    ihit = 1'b0;
    #1 chk("ihit_miss", 0, P_NOI);
    tick(); idle(); br = 1'b1;
    #1 chk("halt_pre_br", 0, P_BR);
    tick(); idle(); hlt = 1'b1;
    #1 chk("halt_wb", 0, P_HWB);
    tick(); idle();
    #1 chk("halted", 0, P_HLT);
    tick(); ihit = 1'b0; br = 1'b1; jr = 1'b1;
    #1 chk("halt_sticky", 0, P_HLT);
    tick(); idle();
    #1 chkc("halt_stall_cnt", scnt[0], 16'd1);
    chkc("halt_flush_cnt", fcnt[0], 16'd1);
    #2 RST = 1'b1;
    #1 chk("async_rst_out", 0, P_RST);
    chkc("async_rst_stall", scnt[0], 16'd0);
    chkc("async_rst_flush", fcnt[0], 16'd0);
    tick();
    RST = 1'b0;
    #1 chk("post_rst_run", 0, P_RUN);

    // counter saturation with CNT_W=4
    do_reset();
    ihit = 1'b0;
    repeat (20) tick();
    idle();
    #1 chkc("sat_cnt4", scnt[3], 16'd15);
    chkc("nosat_cnt16", scnt[0], 16'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
